if_fetch: RTL and testbench
===========================

# if_fetch

Parametrised instruction-fetch stage for the processor datapath. It owns the program counter and the instruction register, and talks to instruction memory through a req/ack handshake, so memories with wait states are supported. It delivers one instruction at a time to decode through a valid/stall interface and accepts branch/jump redirects from execute. It replaces the free-running PC+4 / IR pair of the single-cycle datapath.

## Interface

Parameters:
- PC_W, 32, program counter width
- IADDR_W, 6, instruction-memory word-address width; i_mem_addr = pc[IADDR_W+1:2]
- RESET_PC, 0, PC value loaded on reset (must be 4-byte aligned)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- i_mem_req  out  1  fetch request to instruction memory
- i_mem_addr  out  IADDR_W  word address of the request
- i_mem_ack  in  1  memory completes the request this cycle; i_mem_data valid
- i_mem_data  in  32  instruction word
- stall  in  1  decode cannot accept the held instruction this cycle
- redirect  in  1  load a new PC (taken branch/jump), one-cycle pulse
- redirect_pc  in  PC_W  redirect target
- instr  out  32  instruction register
- instr_pc  out  PC_W  PC of instr
- instr_valid  out  1  instr holds a valid instruction
- pc  out  PC_W  address of the next/outstanding fetch
- misalign_err  out  1  sticky error: misaligned redirect target
- fetch_cnt  out  32  completed fetches (see Configuration)
- stall_cnt  out  32  cycles with instr_valid && stall (see Configuration)

## Operation

- FSM states: FETCH, DRAIN, ERR.
- Consume: instr_valid && !stall at an edge means decode takes instr.
- Slot free: !instr_valid || !stall.
- FETCH: i_mem_req = slot free. i_mem_addr is always pc[IADDR_W+1:2].
- Handshake rule: once i_mem_req is high, req and address stay stable until i_mem_ack. An ack is valid in the same cycle req rises.
- Stall is sampled only at request start. An outstanding request stays asserted until ack even if stall rises.
- On req && ack with no redirect:
  - instr <= i_mem_data, instr_pc <= pc, instr_valid <= 1.
  - pc <= pc + 4, modulo 2^PC_W; wrap-around is legal.
- Consume without a new ack: instr_valid <= 0.
- Redirect has priority over stall and over a returning ack.
  - instr_valid <= 0 (flush).
  - If no request is outstanding, or ack arrives this cycle: data is discarded, pc <= redirect_pc, stay in FETCH.
  - If a request is outstanding without ack: pend_pc <= redirect_pc, go to DRAIN.
- DRAIN: i_mem_req stays 1 with the old address. On ack, data is discarded, pc <= pend_pc, go to FETCH. A further redirect in DRAIN overwrites pend_pc.
- Misaligned redirect (redirect_pc[1:0] != 0): misalign_err <= 1, instr_valid <= 0, go to ERR. A request already outstanding is still drained (req held until ack, data discarded) before req drops.
- ERR: no requests. Only reset leaves ERR.

## Timing

- Reset values: pc = RESET_PC, instr = 0, instr_pc = 0, instr_valid = 0, misalign_err = 0, counters = 0, state = FETCH, pend_pc = 0.
- i_mem_req rises combinationally in the first cycle after reset deasserts.
- Fetch latency: ack in cycle N gives instr_valid in cycle N+1.
- Throughput with ack tied high and no stall: one instruction per cycle, PCs 0, 4, 8, ...
- A redirect in cycle N drives the new target on i_mem_addr in cycle N+1. In DRAIN, the new target appears the cycle after the draining ack.
- Reset in any state, including DRAIN with a request outstanding, clears everything immediately. The memory must tolerate the abandoned request.

## Configuration

- IF_PERF_CNT_EN defined:
  - fetch_cnt increments on each ack that is captured (not discarded).
  - stall_cnt increments on each cycle with instr_valid && stall.
  - Both counters wrap at 2^32.
- IF_PERF_CNT_EN undefined: both ports are tied to 0 and no counter flops are built.

## Test plan

- Reset release, ack tied 1, no stall -> req=1 addr 0 in the first cycle; instr_pc sequence 0, 4, 8 on consecutive cycles; instr equals the memory words.
- Ack delayed 2 cycles per fetch -> req and addr stable while waiting; instr_valid rises one cycle after each ack; one instruction every 3 cycles.
- stall held 3 cycles with instr at pc=4 -> instr and instr_pc frozen, no new req, stall_cnt += 3 (with macro); fetch of pc=8 starts on release.
- Redirect to 0x40 while a request to 0x8 is outstanding, ack 2 cycles later -> DRAIN; the 0x8 data is never valid; next req addr = 0x10 (word address); instr_pc = 0x40.
- Redirect to 0x42 -> misalign_err=1, instr_valid=0, req stays 0 until reset.
- Reset asserted during DRAIN -> pc = RESET_PC, instr_valid=0, state FETCH; fetch restarts at RESET_PC after release.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, instruction register, req/ack memory handshake, redirect drain.
// Optional perf counters are built when IF_PERF_CNT_EN is defined.
module if_fetch #(
  parameter int              PC_W     = 32,
  parameter int              IADDR_W  = 6,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               i_mem_req,
  output logic [IADDR_W-1:0] i_mem_addr,
  input  logic               i_mem_ack,
  input  logic [31:0]        i_mem_data,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [31:0]        instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc,
  output logic               misalign_err,
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        stall_cnt
);

  typedef enum logic [1:0] {S_FETCH, S_DRAIN, S_ERR} state_e;

  state_e          state_q;
  logic [PC_W-1:0] pc_q, pend_pc_q, instr_pc_q;
  logic [31:0]     instr_q;
  logic            ivalid_q, err_q, outst_q;

  logic slot_free, consume, done, misalign;

  assign slot_free = !ivalid_q || !stall;
  assign consume   = ivalid_q && !stall;
  assign misalign  = redirect && (redirect_pc[1:0] != 2'b00);
  assign done      = i_mem_req && i_mem_ack;

  // outst_q keeps req high (and the address stable) once a request has started
  always_comb begin
    i_mem_req = 1'b0;
    case (state_q)
      S_FETCH: i_mem_req = outst_q || slot_free;
      S_DRAIN: i_mem_req = 1'b1;
      S_ERR:   i_mem_req = outst_q;
      default: i_mem_req = 1'b0;
    endcase
  end

  assign i_mem_addr = pc_q[IADDR_W+1:2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      pend_pc_q  <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      ivalid_q   <= 1'b0;
      err_q      <= 1'b0;
      outst_q    <= 1'b0;
    end else begin
      if (consume) ivalid_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          if (redirect) begin
            ivalid_q <= 1'b0;
            if (misalign) begin
              err_q   <= 1'b1;
              state_q <= S_ERR;
              outst_q <= i_mem_req && !i_mem_ack;
            end else if (i_mem_req && !i_mem_ack) begin
              pend_pc_q <= redirect_pc;
              outst_q   <= 1'b1;
              state_q   <= S_DRAIN;
            end else begin
              pc_q    <= redirect_pc;
              outst_q <= 1'b0;
            end
          end else if (done) begin
            instr_q    <= i_mem_data;
            instr_pc_q <= pc_q;
            ivalid_q   <= 1'b1;
            pc_q       <= pc_q + PC_W'(4);
            outst_q    <= 1'b0;
          end else if (i_mem_req) begin
            outst_q <= 1'b1;
          end
        end
        S_DRAIN: begin
          ivalid_q <= 1'b0;
          if (redirect && misalign) begin
            err_q   <= 1'b1;
            state_q <= S_ERR;
            outst_q <= !i_mem_ack;
          end else if (i_mem_ack) begin
            // a redirect arriving with the draining ack is the newest target
            pc_q    <= redirect ? redirect_pc : pend_pc_q;
            outst_q <= 1'b0;
            state_q <= S_FETCH;
          end else if (redirect) begin
            pend_pc_q <= redirect_pc;
          end
        end
        S_ERR: begin
          ivalid_q <= 1'b0;
          if (done) outst_q <= 1'b0;
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign instr        = instr_q;
  assign instr_pc     = instr_pc_q;
  assign instr_valid  = ivalid_q;
  assign pc           = pc_q;
  assign misalign_err = err_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d, stall_cnt_q, stall_cnt_d;
  logic        capture;

  assign capture     = (state_q == S_FETCH) && done && !redirect;
  assign fetch_cnt_d = fetch_cnt_q + {31'b0, capture};
  assign stall_cnt_d = stall_cnt_q + {31'b0, ivalid_q && stall};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  assign fetch_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: streaming, wait states, stall, drain, misalign, reset in DRAIN, PC wrap.
module tb_if_fetch;

`ifdef IF_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        i_mem_req;
  logic [5:0]  i_mem_addr;
  logic        i_mem_ack;
  logic [31:0] i_mem_data;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr, instr_pc, pc, fetch_cnt, stall_cnt;
  logic        instr_valid, misalign_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // memory word at word address a is 0x1000_0000 | a
  assign i_mem_data = 32'h1000_0000 | {26'b0, i_mem_addr};

  if_fetch #(.PC_W(32), .IADDR_W(6), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .i_mem_req(i_mem_req), .i_mem_addr(i_mem_addr), .i_mem_ack(i_mem_ack), .i_mem_data(i_mem_data),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .pc(pc),
    .misalign_err(misalign_err), .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; i_mem_ack = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // reset values
    do_reset();
    reset = 1'b1;
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_err", {31'b0, misalign_err}, 32'd0);
    check("rst_fcnt", fetch_cnt, 32'd0);

    // streaming with ack tied high
    do_reset();
    i_mem_ack = 1'b1;
    #1;
    check("s_req0", {31'b0, i_mem_req}, 32'd1);
    check("s_addr0", {26'b0, i_mem_addr}, 32'd0);
    tick();
    check("s_ipc0", instr_pc, 32'h0);
    check("s_instr0", instr, 32'h1000_0000);
    check("s_valid0", {31'b0, instr_valid}, 32'd1);
    tick();
    check("s_ipc1", instr_pc, 32'h4);
    check("s_instr1", instr, 32'h1000_0001);
    tick();
    check("s_ipc2", instr_pc, 32'h8);
    check("s_pc", pc, 32'hC);
    check("s_fcnt", fetch_cnt, PERF ? 32'd3 : 32'd0);

    // two wait states per fetch
    do_reset();
    #1;
    check("w_req_a", {31'b0, i_mem_req}, 32'd1);
    tick();
    check("w_req_b", {31'b0, i_mem_req}, 32'd1);
    check("w_addr_b", {26'b0, i_mem_addr}, 32'd0);
    check("w_valid_b", {31'b0, instr_valid}, 32'd0);
    tick();
    check("w_req_c", {31'b0, i_mem_req}, 32'd1);
    i_mem_ack = 1'b1;
    tick();
    i_mem_ack = 1'b0;
    #1;
    check("w_valid1", {31'b0, instr_valid}, 32'd1);
    check("w_ipc1", instr_pc, 32'h0);
    check("w_addr1", {26'b0, i_mem_addr}, 32'd1);
    tick();
    check("w_valid_gap", {31'b0, instr_valid}, 32'd0);
    check("w_addr_hold", {26'b0, i_mem_addr}, 32'd1);
    check("w_req_hold", {31'b0, i_mem_req}, 32'd1);
    tick();
    i_mem_ack = 1'b1;
    tick();
    i_mem_ack = 1'b0;
    #1;
    check("w_valid2", {31'b0, instr_valid}, 32'd1);
    check("w_ipc2", instr_pc, 32'h4);

    // stall for three cycles on instr at pc=4
    do_reset();
    i_mem_ack = 1'b1;
    tick();
    tick();
    stall = 1'b1;
    #1;
    check("st_req0", {31'b0, i_mem_req}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("st_ipc", instr_pc, 32'h4);
      check("st_instr", instr, 32'h1000_0001);
      check("st_req", {31'b0, i_mem_req}, 32'd0);
    end
    tick();
    stall = 1'b0;
    #1;
    check("st_cnt", stall_cnt, PERF ? 32'd3 : 32'd0);
    check("st_rel_req", {31'b0, i_mem_req}, 32'd1);
    check("st_rel_addr", {26'b0, i_mem_addr}, 32'd2);
    tick();
    check("st_ipc8", instr_pc, 32'h8);

    // redirect while fetch of 0x8 is outstanding
    do_reset();
    i_mem_ack = 1'b1;
    tick();
    tick();
    i_mem_ack = 1'b0;
    tick();
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    #1;
    check("d_req", {31'b0, i_mem_req}, 32'd1);
    check("d_addr_old", {26'b0, i_mem_addr}, 32'd2);
    check("d_valid", {31'b0, instr_valid}, 32'd0);
    tick();
    i_mem_ack = 1'b1;
    tick();
    i_mem_ack = 1'b0;
    #1;
    check("d_valid_after", {31'b0, instr_valid}, 32'd0);
    check("d_addr_new", {26'b0, i_mem_addr}, 32'h10);
    check("d_pc_new", pc, 32'h40);
    i_mem_ack = 1'b1;
    tick();
    check("d_ipc", instr_pc, 32'h40);
    check("d_instr", instr, 32'h1000_0010);
    check("d_fcnt", fetch_cnt, PERF ? 32'd3 : 32'd0);

    // misaligned redirect locks up until reset
    do_reset();
    i_mem_ack = 1'b1;
    tick();
    redirect = 1'b1; redirect_pc = 32'h42;
    tick();
    redirect = 1'b0;
    #1;
    check("m_err", {31'b0, misalign_err}, 32'd1);
    check("m_valid", {31'b0, instr_valid}, 32'd0);
    check("m_req", {31'b0, i_mem_req}, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect = 1'b0;
    tick();
    check("m_req_late", {31'b0, i_mem_req}, 32'd0);
    check("m_err_late", {31'b0, misalign_err}, 32'd1);

    // reset asserted while draining
    do_reset();
    i_mem_ack = 1'b1;
    tick();
    i_mem_ack = 1'b0;
    tick();
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    check("r_drain_pc", pc, 32'h4);
    reset = 1'b1;
    #1;
    check("r_pc", pc, 32'h0);
    check("r_valid", {31'b0, instr_valid}, 32'd0);
    tick();
    reset = 1'b0;
    i_mem_ack = 1'b1;
    #1;
    check("r_req", {31'b0, i_mem_req}, 32'd1);
    check("r_addr", {26'b0, i_mem_addr}, 32'd0);
    tick();
    check("r_ipc", instr_pc, 32'h0);
    check("r_rvalid", {31'b0, instr_valid}, 32'd1);

    // PC wrap-around from 0xFFFF_FFFC
    do_reset();
    i_mem_ack = 1'b1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    #1;
    check("x_addr", {26'b0, i_mem_addr}, 32'h3F);
    check("x_valid", {31'b0, instr_valid}, 32'd0);
    tick();
    check("x_ipc", instr_pc, 32'hFFFF_FFFC);
    check("x_instr", instr, 32'h1000_003F);
    check("x_pc_wrap", pc, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
